// File: rtl/cacheline_burst_adapter.sv
// ----------------------------------------------------------------------------
// cacheline_burst_adapter
//
// Turns one cache-line read or write into a multi-beat burst transaction
// on the physical memory bus. A 256-bit line becomes 4 x 64-bit beats
// (little-endian: beat 0 carries bits 63:0). The line-aligned address stays
// stable for the whole burst. The cache gets a single-cycle completion pulse.
//
// Parameters
//   s_offset     log2 of line size in bytes (line width = 8 * 2**s_offset)
//   burst_width  bits per memory beat; must divide the line width evenly
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   line_i        line to write (cache side)
//   line_o        assembled read line (cache side)
//   address_i     request byte address (cache side)
//   read_i        line read request, held until resp_o
//   write_i       line write request, held until resp_o (wins over read_i)
//   resp_o        one-cycle completion pulse (cache side)
//   burst_i       read beat data from memory
//   burst_o       write beat data to memory
//   address_o     line-aligned address to memory
//   read_o        memory burst read request
//   write_o       memory burst write request
//   resp_i        memory beat acknowledge, one per beat
//
// Optional feature (macro CLA_EARLY_RESP_EN)
//   When this macro is defined, the DONE cycle is removed. resp_o is raised
//   combinationally together with the last beat acknowledge. For reads, the
//   top beat of line_o is bypassed from burst_i in that cycle.
// ----------------------------------------------------------------------------
module cacheline_burst_adapter #(
    parameter int s_offset    = 5,
    parameter int burst_width = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [(8 << s_offset)-1:0]   line_i,
    output logic [(8 << s_offset)-1:0]   line_o,
    input  logic [31:0]                  address_i,
    input  logic                         read_i,
    input  logic                         write_i,
    output logic                         resp_o,
    input  logic [burst_width-1:0]       burst_i,
    output logic [burst_width-1:0]       burst_o,
    output logic [31:0]                  address_o,
    output logic                         read_o,
    output logic                         write_o,
    input  logic                         resp_i
);

    localparam int line_w = 8 << s_offset;
    localparam int beats  = line_w / burst_width;
    localparam int cnt_w  = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(beats - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [cnt_w-1:0]    cnt_q, cnt_d;
    logic [line_w-1:0]   rline_q, rline_d;   // read line being assembled
    logic [line_w-1:0]   wline_q, wline_d;   // write line latched at request
    logic [31:0]         addr_q, addr_d;
    logic                last_beat;

    // NOTE: every comb output gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rline_d   = rline_q;
        wline_d   = wline_q;
        addr_d    = addr_q;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        burst_o   = '0;
        line_o    = rline_q;
        address_o = addr_q;
        last_beat = resp_i && (cnt_q == last_cnt);

        case (state_q)
            IDLE: begin
                // Requests are sampled only here. Write takes priority over read.
                if (write_i) begin
                    wline_d = line_i;
                    addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (read_i) begin
                    addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end

            RD_BURST: begin
                read_o = 1'b1;
                if (resp_i) begin
                    rline_d[int'(cnt_q)*burst_width +: burst_width] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                end
                if (last_beat) begin
                    cnt_d = '0;
`ifdef CLA_EARLY_RESP_EN
                    // The top beat is still in flight into rline_q, so forward it.
                    resp_o  = 1'b1;
                    line_o[line_w-1 -: burst_width] = burst_i;
                    state_d = IDLE;
`else
                    state_d = DONE;
`endif
                end
            end

            WR_BURST: begin
                write_o = 1'b1;
                burst_o = wline_q[int'(cnt_q)*burst_width +: burst_width];
                if (resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (last_beat) begin
                    cnt_d = '0;
`ifdef CLA_EARLY_RESP_EN
                    resp_o  = 1'b1;
                    state_d = IDLE;
`else
                    state_d = DONE;
`endif
                end
            end

            DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset as well, because line_o and address_o have defined reset values.
            state_q <= IDLE;
            cnt_q   <= '0;
            rline_q <= '0;
            wline_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rline_q <= rline_d;
            wline_q <= wline_d;
            addr_q  <= addr_d;
        end
    end

endmodule
